// File: rtl/fila_param_if.sv
// ---------------------------------------------------------------------------
// fila_param_if
// Bundles the producer/consumer side of the fila_param queue.
//   master : drives flush_in, data_in, enqueue_in, dequeue_in and
//            observes data_out, out_valid, len_out and the status flags.
//   slave  : the queue itself (the mirror image of master).
// Signals:
//   flush_in         synchronous clear of contents and error flags
//   data_in          word written on an accepted enqueue
//   enqueue_in       level; a rising edge requests one enqueue
//   dequeue_in       level; a rising edge requests one dequeue
//   data_out         last dequeued word
//   out_valid        one-cycle pulse when data_out was updated by a dequeue
//   len_out          current entry count, 0..DEPTH
//   full_out         queue holds DEPTH entries
//   empty_out        queue holds no entries
//   almost_full_out  len_out >= AF_LEVEL of the attached queue
//   overflow_out     sticky: an enqueue was dropped
//   underflow_out    sticky: a dequeue found the queue empty
// ---------------------------------------------------------------------------
interface fila_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int LEN_W = $clog2(DEPTH) + 1;

    logic              flush_in;
    logic [DATA_W-1:0] data_in;
    logic              enqueue_in;
    logic              dequeue_in;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic [LEN_W-1:0]  len_out;
    logic              full_out;
    logic              empty_out;
    logic              almost_full_out;
    logic              overflow_out;
    logic              underflow_out;

    modport master (
        output flush_in, data_in, enqueue_in, dequeue_in,
        input  data_out, out_valid, len_out, full_out, empty_out,
               almost_full_out, overflow_out, underflow_out
    );

    modport slave (
        input  flush_in, data_in, enqueue_in, dequeue_in,
        output data_out, out_valid, len_out, full_out, empty_out,
               almost_full_out, overflow_out, underflow_out
    );
endinterface

// File: rtl/fila_param.sv
// ---------------------------------------------------------------------------
// fila_param
// Parametrised circular FIFO for the 10 kHz control domain. Each operation
// is triggered by a rising edge on enqueue_in or dequeue_in; holding a level
// high yields exactly one operation. Enqueue and dequeue may occur together.
// Ports:
//   clock_10KHz  single clock, all state updates on posedge
//   reset        asynchronous, active-low
//   bus          fila_param_if.slave (data, requests, flush, status outputs)
// Parameters:
//   DATA_W    word width
//   DEPTH     entry count, power of two, >= 2
//   AF_LEVEL  almost_full_out threshold on len_out (1..DEPTH)
// ---------------------------------------------------------------------------
module fila_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic        clock_10KHz,
    input  logic        reset,
    fila_param_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [LEN_W-1:0]  len_q, len_next;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              overflow_q, underflow_q;
    logic              enq_q, deq_q;

    logic enq_req, deq_req;
    logic is_full, is_empty;
    logic do_enq, do_deq;

    assign enq_req  = bus.enqueue_in & ~enq_q;
    assign deq_req  = bus.dequeue_in & ~deq_q;
    assign is_full  = (len_q == LEN_W'(DEPTH));
    assign is_empty = (len_q == '0);

    // A full queue still accepts a write when a read happens on the same
    // edge: the read uses the old head, so a slot is freed in time.
    assign do_enq = enq_req & (~is_full | deq_req);
    assign do_deq = deq_req & ~is_empty;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        len_next = len_q;
        case ({do_enq, do_deq})
            2'b10:   len_next = len_q + LEN_W'(1);
            2'b01:   len_next = len_q - LEN_W'(1);
            default: len_next = len_q;
        endcase
    end

    // NOTE: storage has no reset; pointers and len_q are reset, so stale
    // words are unreachable and the array can map onto plain RAM.
    always_ff @(posedge clock_10KHz) begin
        if (do_enq && !bus.flush_in) begin
            mem[tail_q] <= bus.data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock_10KHz or negedge reset) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            len_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            enq_q       <= 1'b0;
            deq_q       <= 1'b0;
        end else begin
            // Edge registers track the inputs even during a flush.
            enq_q <= bus.enqueue_in;
            deq_q <= bus.dequeue_in;

            if (bus.flush_in) begin
                head_q      <= '0;
                tail_q      <= '0;
                len_q       <= '0;
                data_q      <= '0;
                valid_q     <= 1'b0;
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                len_q   <= len_next;
                valid_q <= do_deq;

                if (do_enq) begin
                    tail_q <= tail_q + PTR_W'(1);
                end

                if (do_deq) begin
                    data_q <= mem[head_q];
                    head_q <= head_q + PTR_W'(1);
                end else if (deq_req) begin
                    // Dequeue on empty: no bypass from a same-edge enqueue.
                    data_q      <= '0;
                    underflow_q <= 1'b1;
                end

                if (enq_req && is_full && !deq_req) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out        = data_q;
    assign bus.out_valid       = valid_q;
    assign bus.len_out         = len_q;
    assign bus.full_out        = is_full;
    assign bus.empty_out       = is_empty;
    assign bus.almost_full_out = (len_q >= LEN_W'(AF_LEVEL));
    assign bus.overflow_out    = overflow_q;
    assign bus.underflow_out   = underflow_q;
endmodule

// File: tb/tb_fila_param.sv
`timescale 1us/1ns
module tb_fila_param;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fila_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    fila_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clock_10KHz(clk),
        .reset      (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Reference model: a queue plus the externally visible registers.
    logic [7:0] m_q [$];
    logic [7:0] m_data;
    logic       m_valid, m_ovf, m_udf, m_enq_prev, m_deq_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_data = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
        m_enq_prev = 0; m_deq_prev = 0;
    endtask

    task automatic model_edge(input logic e, input logic d, input logic f, input logic [7:0] din);
        logic er, dr;
        er = e & !m_enq_prev;
        dr = d & !m_deq_prev;
        m_enq_prev = e;
        m_deq_prev = d;
        if (f) begin
            m_q.delete();
            m_ovf = 0; m_udf = 0; m_data = '0; m_valid = 0;
        end else begin
            m_valid = 0;
            if (dr) begin
                if (m_q.size() > 0) begin
                    m_data  = m_q.pop_front();
                    m_valid = 1;
                end else begin
                    m_data = '0;
                    m_udf  = 1;
                end
            end
            if (er) begin
                if (m_q.size() < DEPTH) m_q.push_back(din);
                else                    m_ovf = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = m_q.size();
        check({tag, ".data"},  bus.data_out,        m_data);
        check({tag, ".valid"}, bus.out_valid,       m_valid);
        check({tag, ".len"},   bus.len_out,         n);
        check({tag, ".full"},  bus.full_out,        n == DEPTH);
        check({tag, ".empty"}, bus.empty_out,       n == 0);
        check({tag, ".af"},    bus.almost_full_out, n >= AF_LEVEL);
        check({tag, ".ovf"},   bus.overflow_out,    m_ovf);
        check({tag, ".udf"},   bus.underflow_out,   m_udf);
    endtask

    // One clock cycle: apply levels, take the edge, compare 1 time unit later.
    task automatic cyc(input string tag, input logic e, input logic d, input logic f, input logic [7:0] din);
        bus.enqueue_in = e;
        bus.dequeue_in = d;
        bus.flush_in   = f;
        bus.data_in    = din;
        @(posedge clk);
        model_edge(e, d, f, din);
        #1;
        check_all(tag);
    endtask

    task automatic enq(input string tag, input logic [7:0] din);
        cyc(tag, 1, 0, 0, din);
        cyc(tag, 0, 0, 0, din);
    endtask

    task automatic deq(input string tag);
        cyc(tag, 0, 1, 0, 8'h00);
        cyc(tag, 0, 0, 0, 8'h00);
    endtask

    initial begin
        int len_before;
        n_checks = 0;
        n_fail   = 0;
        bus.enqueue_in = 0; bus.dequeue_in = 0; bus.flush_in = 0; bus.data_in = '0;

        // Reset state
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1;

        // In-order fill and drain
        for (int i = 0; i < 8; i++) enq("fill", 8'h11 + 8'(i));
        check("fill.len8", bus.len_out, 8);
        for (int i = 0; i < 8; i++) begin
            cyc("drain", 0, 1, 0, 8'h00);
            check("drain.order", bus.data_out, 8'h11 + 8'(i));
            check("drain.pulse", bus.out_valid, 1);
            cyc("drain", 0, 0, 0, 8'h00);
            check("drain.pulse_off", bus.out_valid, 0);
        end

        // Overflow: 9th enqueue dropped
        for (int i = 0; i < 8; i++) enq("ovf_fill", 8'(i + 1));
        enq("ovf", 8'hAA);
        check("ovf.flag", bus.overflow_out, 1);
        check("ovf.len", bus.len_out, 8);
        for (int i = 0; i < 8; i++) begin
            deq("ovf_drain");
            check("ovf_drain.noAA", bus.data_out == 8'hAA, 0);
        end

        // Underflow then flush
        deq("udf");
        check("udf.flag", bus.underflow_out, 1);
        check("udf.data", bus.data_out, 0);
        cyc("flush", 0, 0, 1, 8'h00);
        cyc("flush_rel", 0, 0, 0, 8'h00);
        check("flush.ovf", bus.overflow_out, 0);
        check("flush.udf", bus.underflow_out, 0);

        // Simultaneous enq+deq on a full queue
        for (int i = 0; i < 8; i++) enq("sim_fill", 8'(i + 1));
        cyc("sim", 1, 1, 0, 8'h99);
        check("sim.data", bus.data_out, 8'h01);
        check("sim.len", bus.len_out, 8);
        check("sim.ovf", bus.overflow_out, 0);
        cyc("sim_rel", 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) deq("sim_drain");
        check("sim_drain.last", bus.data_out, 8'h99);

        // Simultaneous enq+deq on an empty queue: enqueue wins, dequeue underflows
        cyc("sim_empty", 1, 1, 0, 8'h5C);
        check("sim_empty.len", bus.len_out, 1);
        check("sim_empty.udf", bus.underflow_out, 1);
        cyc("sim_empty_rel", 0, 0, 0, 8'h00);
        cyc("flush2", 0, 0, 1, 8'h00);
        cyc("flush2_rel", 0, 0, 0, 8'h00);

        // Held enqueue level gives one entry
        len_before = int'(bus.len_out);
        for (int i = 0; i < 5; i++) cyc("hold", 1, 0, 0, 8'h77);
        cyc("hold_rel", 0, 0, 0, 8'h00);
        check("hold.one", bus.len_out, len_before + 1);
        deq("hold_drain");

        // Pointer wrap across 12 pairs
        for (int i = 0; i < 12; i++) begin
            enq("wrap_enq", 8'hC0 + 8'(i));
            deq("wrap_deq");
            check("wrap.order", bus.data_out, 8'hC0 + 8'(i));
        end

        // Asynchronous reset between edges aborts everything
        enq("pre_rst", 8'h3C);
        enq("pre_rst", 8'h3D);
        bus.enqueue_in = 1;
        bus.data_in    = 8'hE1;
        #10 rst = 0;
        model_reset();
        #10 check_all("mid_rst");
        #10 rst = 1;
        cyc("post_rst", 0, 0, 0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 39) == 0), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
